// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared L1I refill types and constants
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_TAGWR = 2'd3
    } refill_state_e;

    localparam int DEF_OFFSET_SIZE = 5;
    localparam int DEF_INDEX_SIZE  = 8;
    localparam int DEF_BUS_WIDTH   = 64;
    localparam int ADDR_WIDTH      = 64;

    // Stored tag word layout: valid flag in bit 0, tag above it.
    localparam int TAG_VALID_BIT   = 0;

endpackage

// File: rtl/icache_tag_compare.sv
// rtl/icache_tag_compare.sv - combinational valid/tag compare producing a hit
module icache_tag_compare
    import icache_pkg::*;
#(
    parameter int tagSize = 51
) (
    input  logic [tagSize:0]   queriedTag_i,
    input  logic [tagSize-1:0] tag_i,
    output logic               hit_o
);

    // A hit needs a valid entry whose stored tag matches the request.
    always_comb begin
        hit_o = queriedTag_i[TAG_VALID_BIT] && (queriedTag_i[tagSize:1] == tag_i);
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - L1I hit/miss decision and line refill; optional ICACHE_PERF_CNT_EN hit/miss counters
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int offsetSize   = DEF_OFFSET_SIZE,
    parameter int indexSize    = DEF_INDEX_SIZE,
    parameter int tagSize      = ADDR_WIDTH - (offsetSize + indexSize),
    parameter int busWidth     = DEF_BUS_WIDTH,
    parameter int beatsPerLine = (2 ** offsetSize) * 8 / busWidth,
    localparam int BEAT_W      = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flushPipeline_i,
    input  logic                  enable_i,
    input  logic [tagSize-1:0]    tag_i,
    input  logic [indexSize-1:0]  index_i,
    input  logic [offsetSize-1:0] offset_i,
    input  logic [tagSize:0]      queriedTag_i,
    output logic                  hit_o,
    output logic [tagSize-1:0]    tag_o,
    output logic [indexSize-1:0]  index_o,
    output logic [offsetSize-1:0] offset_o,
    output logic                  tagQueryStall_o,
    output logic                  reqValid_o,
    input  logic                  reqReady_i,
    output logic [ADDR_WIDTH-1:0] reqAddr_o,
    input  logic                  fillValid_i,
    input  logic [busWidth-1:0]   fillData_i,
    output logic                  dataWrEn_o,
    output logic [indexSize-1:0]  dataWrIndex_o,
    output logic [BEAT_W-1:0]     dataWrBeat_o,
    output logic [busWidth-1:0]   dataWrData_o,
    output logic [tagSize-1:0]    newTag_o,
    output logic [indexSize-1:0]  newIndex_o,
    output logic                  updateEnable_o
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hitCount_o,
    output logic [31:0]           missCount_o
`endif
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(beatsPerLine - 1);

    refill_state_e         state_q, state_d;
    logic                  hit_q, hit_d;
    logic [tagSize-1:0]    ptag_q, ptag_d;
    logic [indexSize-1:0]  pidx_q, pidx_d;
    logic [offsetSize-1:0] poff_q, poff_d;
    logic [tagSize-1:0]    lat_tag_q, lat_tag_d;
    logic [indexSize-1:0]  lat_idx_q, lat_idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  wr_en_q, wr_en_d;
    logic [BEAT_W-1:0]     wr_beat_q, wr_beat_d;
    logic [busWidth-1:0]   wr_data_q, wr_data_d;
    logic [indexSize-1:0]  wr_idx_q, wr_idx_d;
    logic                  lookup_hit;
    logic                  query_taken;

    icache_tag_compare #(.tagSize(tagSize)) u_tag_compare (
        .queriedTag_i (queriedTag_i),
        .tag_i        (tag_i),
        .hit_o        (lookup_hit)
    );

    // A flushed query is dropped before it can hit or start a refill.
    assign query_taken = (state_q == ST_IDLE) && enable_i && !flushPipeline_i;

    // State register and all datapath registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            hit_q     <= 1'b0;
            ptag_q    <= '0;
            pidx_q    <= '0;
            poff_q    <= '0;
            lat_tag_q <= '0;
            lat_idx_q <= '0;
            beat_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_beat_q <= '0;
            wr_data_q <= '0;
            wr_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            ptag_q    <= ptag_d;
            pidx_q    <= pidx_d;
            poff_q    <= poff_d;
            lat_tag_q <= lat_tag_d;
            lat_idx_q <= lat_idx_d;
            beat_q    <= beat_d;
            wr_en_q   <= wr_en_d;
            wr_beat_q <= wr_beat_d;
            wr_data_q <= wr_data_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    // Next-state logic; hit and data-write registers are single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        hit_d     = 1'b0;
        ptag_d    = '0;
        pidx_d    = '0;
        poff_d    = '0;
        lat_tag_d = lat_tag_q;
        lat_idx_d = lat_idx_q;
        beat_d    = beat_q;
        wr_en_d   = 1'b0;
        wr_beat_d = '0;
        wr_data_d = '0;
        wr_idx_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (query_taken) begin
                    if (lookup_hit) begin
                        hit_d  = 1'b1;
                        ptag_d = tag_i;
                        pidx_d = index_i;
                        poff_d = offset_i;
                    end else begin
                        lat_tag_d = tag_i;
                        lat_idx_d = index_i;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A handshake wins over a flush: the request is already issued.
                if (reqReady_i) begin
                    state_d = ST_FILL;
                    beat_d  = '0;
                end else if (flushPipeline_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fillValid_i) begin
                    wr_en_d   = 1'b1;
                    wr_beat_d = beat_q;
                    wr_data_d = fillData_i;
                    wr_idx_d  = lat_idx_q;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_TAGWR;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_TAGWR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hit_o           = hit_q;
    assign tag_o           = ptag_q;
    assign index_o         = pidx_q;
    assign offset_o        = poff_q;
    assign tagQueryStall_o = (state_q != ST_IDLE);
    assign reqValid_o      = (state_q == ST_REQ);
    assign reqAddr_o       = (state_q == ST_REQ) ? {lat_tag_q, lat_idx_q, {offsetSize{1'b0}}} : '0;
    assign dataWrEn_o      = wr_en_q;
    assign dataWrIndex_o   = wr_idx_q;
    assign dataWrBeat_o    = wr_beat_q;
    assign dataWrData_o    = wr_data_q;
    assign updateEnable_o  = (state_q == ST_TAGWR);
    assign newTag_o        = (state_q == ST_TAGWR) ? lat_tag_q : '0;
    assign newIndex_o      = (state_q == ST_TAGWR) ? lat_idx_q : '0;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Count every accepted IDLE lookup decision; only reset clears them.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (query_taken) begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hitCount_o  = hit_cnt_q;
    assign missCount_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    localparam int OFS = 5;
    localparam int IDX = 8;
    localparam int TGS = 64 - (OFS + IDX);
    localparam int BW  = 64;

    logic           clock;
    logic           reset_i;
    logic           flushPipeline_i;
    logic           enable_i;
    logic [TGS-1:0] tag_i;
    logic [IDX-1:0] index_i;
    logic [OFS-1:0] offset_i;
    logic [TGS:0]   queriedTag_i;
    logic           hit_o;
    logic [TGS-1:0] tag_o;
    logic [IDX-1:0] index_o;
    logic [OFS-1:0] offset_o;
    logic           tagQueryStall_o;
    logic           reqValid_o;
    logic           reqReady_i;
    logic [63:0]    reqAddr_o;
    logic           fillValid_i;
    logic [BW-1:0]  fillData_i;
    logic           dataWrEn_o;
    logic [IDX-1:0] dataWrIndex_o;
    logic [1:0]     dataWrBeat_o;
    logic [BW-1:0]  dataWrData_o;
    logic [TGS-1:0] newTag_o;
    logic [IDX-1:0] newIndex_o;
    logic           updateEnable_o;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]    hitCount_o;
    logic [31:0]    missCount_o;
`endif

    int passed = 0;
    int total  = 0;

    icache_refill_ctrl dut (
        .clock_i         (clock),
        .reset_i         (reset_i),
        .flushPipeline_i (flushPipeline_i),
        .enable_i        (enable_i),
        .tag_i           (tag_i),
        .index_i         (index_i),
        .offset_i        (offset_i),
        .queriedTag_i    (queriedTag_i),
        .hit_o           (hit_o),
        .tag_o           (tag_o),
        .index_o         (index_o),
        .offset_o        (offset_o),
        .tagQueryStall_o (tagQueryStall_o),
        .reqValid_o      (reqValid_o),
        .reqReady_i      (reqReady_i),
        .reqAddr_o       (reqAddr_o),
        .fillValid_i     (fillValid_i),
        .fillData_i      (fillData_i),
        .dataWrEn_o      (dataWrEn_o),
        .dataWrIndex_o   (dataWrIndex_o),
        .dataWrBeat_o    (dataWrBeat_o),
        .dataWrData_o    (dataWrData_o),
        .newTag_o        (newTag_o),
        .newIndex_o      (newIndex_o),
        .updateEnable_o  (updateEnable_o)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hitCount_o      (hitCount_o),
        .missCount_o     (missCount_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic query(input logic [TGS-1:0] t, input logic [IDX-1:0] idx,
                         input logic [OFS-1:0] ofs, input logic [TGS:0] q);
        tag_i        = t;
        index_i      = idx;
        offset_i     = ofs;
        queriedTag_i = q;
        enable_i     = 1'b1;
        tick();
        enable_i     = 1'b0;
    endtask

    task automatic fill_beat(input int b, input logic [IDX-1:0] idx, input logic [BW-1:0] d);
        fillValid_i = 1'b1;
        fillData_i  = d;
        tick();
        fillValid_i = 1'b0;
        chk($sformatf("wr_en_b%0d", b), 64'(dataWrEn_o), 64'd1);
        chk($sformatf("wr_beat_b%0d", b), 64'(dataWrBeat_o), 64'(b));
        chk($sformatf("wr_data_b%0d", b), dataWrData_o, d);
        chk($sformatf("wr_idx_b%0d", b), 64'(dataWrIndex_o), 64'(idx));
        chk($sformatf("stall_b%0d", b), 64'(tagQueryStall_o), 64'd1);
        chk($sformatf("upd_b%0d", b), 64'(updateEnable_o), (b == 3) ? 64'd1 : 64'd0);
    endtask

    logic [TGS-1:0] t2, t3, t4, t5;
    logic [63:0]    exp_addr;

    initial begin
        reset_i = 1'b1; flushPipeline_i = 1'b0; enable_i = 1'b0;
        tag_i = '0; index_i = '0; offset_i = '0; queriedTag_i = '0;
        reqReady_i = 1'b0; fillValid_i = 1'b0; fillData_i = '0;
        tick(); tick();
        chk("rst_hit", 64'(hit_o), 64'd0);
        chk("rst_stall", 64'(tagQueryStall_o), 64'd0);
        chk("rst_reqv", 64'(reqValid_o), 64'd0);
        chk("rst_addr", reqAddr_o, 64'd0);
        chk("rst_wren", 64'(dataWrEn_o), 64'd0);
        chk("rst_upd", 64'(updateEnable_o), 64'd0);
        chk("rst_newtag", 64'(newTag_o), 64'd0);
        reset_i = 1'b0;
        tick();

        // Hit: one-cycle pulse with passthrough.
        query(51'h1234, 8'h10, 5'h04, {51'h1234, 1'b1});
        chk("hit_pulse", 64'(hit_o), 64'd1);
        chk("hit_tag", 64'(tag_o), 64'h1234);
        chk("hit_idx", 64'(index_o), 64'h10);
        chk("hit_ofs", 64'(offset_o), 64'h04);
        chk("hit_stall", 64'(tagQueryStall_o), 64'd0);
        chk("hit_reqv", 64'(reqValid_o), 64'd0);
        tick();
        chk("hit_once", 64'(hit_o), 64'd0);
        chk("hit_tag_clr", 64'(tag_o), 64'd0);

        // Cold miss with ready held low for 3 cycles.
        t2 = 51'h5_5555;
        exp_addr = {t2, 8'h3A, 5'h00};
        query(t2, 8'h3A, 5'h1F, {51'h0, 1'b0});
        chk("cold_hit", 64'(hit_o), 64'd0);
        chk("cold_stall", 64'(tagQueryStall_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cold_reqv_%0d", i), 64'(reqValid_o), 64'd1);
            chk($sformatf("cold_addr_%0d", i), reqAddr_o, exp_addr);
            tick();
        end
        chk("cold_reqv_3", 64'(reqValid_o), 64'd1);
        reqReady_i = 1'b1;
        tick();
        reqReady_i = 1'b0;
        chk("cold_reqv_done", 64'(reqValid_o), 64'd0);
        chk("cold_fill_stall", 64'(tagQueryStall_o), 64'd1);
        for (int b = 0; b < 4; b++) begin
            fill_beat(b, 8'h3A, 64'hC0DE_0000_0000_0000 + 64'(b));
            if (b == 3) begin
                chk("cold_newidx", 64'(newIndex_o), 64'h3A);
                chk("cold_newtag", 64'(newTag_o), 64'(t2));
            end else begin
                chk($sformatf("cold_newtag0_%0d", b), 64'(newTag_o), 64'd0);
                tick();
                chk($sformatf("cold_gap_%0d", b), 64'(dataWrEn_o), 64'd0);
            end
        end
        tick();
        chk("cold_upd_once", 64'(updateEnable_o), 64'd0);
        chk("cold_newidx_clr", 64'(newIndex_o), 64'd0);
        chk("cold_stall_drop", 64'(tagQueryStall_o), 64'd0);
        chk("cold_nohit", 64'(hit_o), 64'd0);

        // Fill beats outside FILL are ignored.
        fillValid_i = 1'b1;
        tick();
        fillValid_i = 1'b0;
        chk("idle_fill_ign", 64'(dataWrEn_o), 64'd0);

        // Conflict miss, then the replayed query hits.
        t3 = 51'h777;
        t4 = 51'h888;
        query(t4, 8'h05, 5'h08, {t3, 1'b1});
        chk("conf_hit", 64'(hit_o), 64'd0);
        chk("conf_stall", 64'(tagQueryStall_o), 64'd1);
        reqReady_i = 1'b1;
        tick();
        reqReady_i = 1'b0;
        for (int b = 0; b < 4; b++) fill_beat(b, 8'h05, 64'h1111_2222_3333_0000 + 64'(b));
        chk("conf_newtag", 64'(newTag_o), 64'(t4));
        tick();
        query(t4, 8'h05, 5'h08, {t4, 1'b1});
        chk("conf_replay_hit", 64'(hit_o), 64'd1);
        chk("conf_replay_tag", 64'(tag_o), 64'(t4));

        // Flush in REQ before ready aborts.
        query(51'h99, 8'h22, 5'h00, {51'h0, 1'b0});
        chk("flreq_reqv", 64'(reqValid_o), 64'd1);
        flushPipeline_i = 1'b1;
        tick();
        flushPipeline_i = 1'b0;
        chk("flreq_reqv_off", 64'(reqValid_o), 64'd0);
        chk("flreq_stall_off", 64'(tagQueryStall_o), 64'd0);
        chk("flreq_addr_off", reqAddr_o, 64'd0);

        // Flush in FILL after beat 1 still completes the refill.
        t5 = 51'hABC;
        query(t5, 8'h44, 5'h00, {51'h0, 1'b0});
        reqReady_i = 1'b1;
        tick();
        reqReady_i = 1'b0;
        fill_beat(0, 8'h44, 64'h10);
        fill_beat(1, 8'h44, 64'h11);
        flushPipeline_i = 1'b1;
        tick();
        flushPipeline_i = 1'b0;
        chk("flfill_stall", 64'(tagQueryStall_o), 64'd1);
        fill_beat(2, 8'h44, 64'h12);
        fill_beat(3, 8'h44, 64'h13);
        chk("flfill_newidx", 64'(newIndex_o), 64'h44);
        chk("flfill_nohit", 64'(hit_o), 64'd0);
        tick();
        chk("flfill_idle", 64'(tagQueryStall_o), 64'd0);
        chk("flfill_nohit2", 64'(hit_o), 64'd0);

        // Reset during FILL.
        query(51'h321, 8'h66, 5'h00, {51'h0, 1'b0});
        reqReady_i = 1'b1;
        tick();
        reqReady_i = 1'b0;
        fill_beat(0, 8'h66, 64'h20);
        reset_i = 1'b1;
        fillValid_i = 1'b1;
        fillData_i = 64'h21;
        tick();
        reset_i = 1'b0;
        chk("rstf_wren", 64'(dataWrEn_o), 64'd0);
        chk("rstf_stall", 64'(tagQueryStall_o), 64'd0);
        chk("rstf_reqv", 64'(reqValid_o), 64'd0);
        chk("rstf_upd", 64'(updateEnable_o), 64'd0);
        chk("rstf_wrdata", dataWrData_o, 64'd0);
        tick();
        fillValid_i = 1'b0;
        chk("rstf_fill_ign", 64'(dataWrEn_o), 64'd0);
        query(51'h1234, 8'h10, 5'h02, {51'h1234, 1'b1});
        chk("rstf_hit", 64'(hit_o), 64'd1);
        chk("rstf_hit_ofs", 64'(offset_o), 64'h02);

`ifdef ICACHE_PERF_CNT_EN
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("perf_rst_hits", 64'(hitCount_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            query(51'h42, 8'h01, 5'h00, {51'h42, 1'b1});
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            query(51'h43, 8'h02, 5'h00, {51'h0, 1'b0});
            flushPipeline_i = 1'b1;
            tick();
            flushPipeline_i = 1'b0;
        end
        chk("perf_hits", 64'(hitCount_o), 64'd3);
        chk("perf_misses", 64'(missCount_o), 64'd2);
        flushPipeline_i = 1'b1;
        tick();
        flushPipeline_i = 1'b0;
        chk("perf_hits_flush", 64'(hitCount_o), 64'd3);
        chk("perf_misses_flush", 64'(missCount_o), 64'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
